// File: rtl/i2c_master_core.sv
// i2c_master_core -- single-byte I2C master (one write or one read per request).
//
// Ports
//   clk        system clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   start      one-cycle request, only looked at while idle
//   addr       7-bit slave address, sent MSB first
//   data_in    byte to write, sent MSB first
//   rw         0 = write one byte, 1 = read one byte
//   data_out   last byte read from the slave
//   ack_error  slave NACKed the address or the write byte in the last transaction
//   busy       high while a transaction is in progress
//   sda        open-drain data line (driven low or released)
//   scl        push-pull bus clock
//
// State table
//   state    | meaning
//   IDLE     | bus released, waiting for start
//   START    | sda low while scl high, two quarters
//   ADDR     | shift out addr[6:0] then rw
//   ADDR_ACK | release sda, sample slave ACK for the address
//   WRITE    | shift out data_in[7:0]
//   WACK     | release sda, sample slave ACK for the data byte
//   READ     | release sda, shift in 8 bits from the slave
//   RNACK    | release sda for one bit (master NACK ends the read)
//   STOP     | scl low/sda low, scl high/sda low, scl high/sda released
module i2c_master_core #(
    parameter int DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic [7:0] data_in,
    input  logic       rw,
    output logic [7:0] data_out,
    output logic       ack_error,
    output logic       busy,
    inout  wire        sda,
    output logic       scl
);

    localparam int QW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [QW-1:0] Q_RELOAD = QW'(DIV - 1);

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, WRITE, WACK, READ, RNACK, STOP
    } state_t;

    state_t        state, state_n;
    logic [QW-1:0] q_cnt;
    logic [1:0]    quarter;
    logic [2:0]    bit_cnt;
    logic [6:0]    addr_q;
    logic [7:0]    data_q;
    logic          rw_q;
    logic          ack_bit;
    logic [7:0]    rx_shift;
    logic [7:0]    addr_byte;
    logic          sda_low;
    logic          sda_in;
    logic          tick;
    logic          sample;
    logic          slot_end;

    assign sda       = sda_low ? 1'b0 : 1'bz;
    assign sda_in    = sda;
    assign addr_byte = {addr_q, rw_q};
    assign busy      = (state != IDLE);

    // Quarter timer: down-counter, one quarter ends when it reaches zero.
    assign tick     = (q_cnt == '0);
    assign sample   = tick && (quarter == 2'd2);
    assign slot_end = tick && (quarter == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        scl     = 1'b1;
        sda_low = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_n = START;
            end
            START: begin
                sda_low = 1'b1;
                if (tick && (quarter == 2'd1)) state_n = ADDR;
            end
            ADDR: begin
                scl     = quarter[1];
                sda_low = ~addr_byte[bit_cnt];
                if (slot_end && (bit_cnt == 3'd0)) state_n = ADDR_ACK;
            end
            ADDR_ACK: begin
                scl = quarter[1];
                if (slot_end) state_n = ack_bit ? STOP : (rw_q ? READ : WRITE);
            end
            WRITE: begin
                scl     = quarter[1];
                sda_low = ~data_q[bit_cnt];
                if (slot_end && (bit_cnt == 3'd0)) state_n = WACK;
            end
            WACK: begin
                scl = quarter[1];
                if (slot_end) state_n = STOP;
            end
            READ: begin
                scl = quarter[1];
                if (slot_end && (bit_cnt == 3'd0)) state_n = RNACK;
            end
            RNACK: begin
                scl = quarter[1];
                if (slot_end) state_n = STOP;
            end
            STOP: begin
                scl     = (quarter != 2'd0);
                sda_low = (quarter != 2'd2);
                if (tick && (quarter == 2'd2)) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_cnt     <= Q_RELOAD;
            quarter   <= 2'd0;
            bit_cnt   <= 3'd0;
            addr_q    <= 7'd0;
            data_q    <= 8'd0;
            rw_q      <= 1'b0;
            ack_bit   <= 1'b0;
            rx_shift  <= 8'd0;
            data_out  <= 8'd0;
            ack_error <= 1'b0;
        end else begin
            if ((state == IDLE) || tick) q_cnt <= Q_RELOAD;
            else                         q_cnt <= q_cnt - QW'(1);

            // Every state begins at quarter 0.
            if (state_n != state) quarter <= 2'd0;
            else if (tick)        quarter <= quarter + 2'd1;

            if ((state == IDLE) && start) begin
                addr_q    <= addr;
                data_q    <= data_in;
                rw_q      <= rw;
                bit_cnt   <= 3'd7;
                ack_error <= 1'b0;
            end

            // Wraps 0 -> 7 after the last address bit, ready for the data byte.
            if (slot_end && ((state == ADDR) || (state == WRITE) || (state == READ)))
                bit_cnt <= bit_cnt - 3'd1;

            if (sample) begin
                if ((state == ADDR_ACK) || (state == WACK)) ack_bit <= sda_in;
                if (state == READ) rx_shift <= {rx_shift[6:0], sda_in};
            end

            if (slot_end) begin
                if (((state == ADDR_ACK) || (state == WACK)) && ack_bit) ack_error <= 1'b1;
                if ((state == READ) && (bit_cnt == 3'd0)) data_out <= rx_shift;
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_core.sv
module tb_i2c_master_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [6:0] addr;
    logic [7:0] data_in;
    logic       rw;
    logic [7:0] data_out;
    logic       ack_error;
    logic       busy;
    logic       scl;
    wire        sda;

    pullup (sda);

    always #5 clk = ~clk;

    i2c_master_core #(.DIV(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .addr      (addr),
        .data_in   (data_in),
        .rw        (rw),
        .data_out  (data_out),
        .ack_error (ack_error),
        .busy      (busy),
        .sda       (sda),
        .scl       (scl)
    );

    // Behavioural slave at 7'h51 plus a bus logger (bit value at each scl rise).
    logic       s_low = 1'b0;
    logic       scl_p = 1'b1;
    logic       sda_p = 1'b1;
    logic       scl_now, sda_now;
    int         rises = 0;
    logic [7:0] s_sh = 8'h00;
    logic [7:0] s_wtmp = 8'h00;
    logic [7:0] s_wbyte = 8'h00;
    logic [7:0] s_rbyte = 8'h00;
    logic       s_match = 1'b0;
    logic       s_rw = 1'b0;
    int         stop_cnt = 0;
    bit         bus_bits[$];

    assign sda = s_low ? 1'b0 : 1'bz;

    always @(negedge clk) begin
        scl_now = scl;
        sda_now = sda;
        if (scl_p && scl_now && sda_p && !sda_now) begin
            rises = 0;
            bus_bits.delete();
            s_low = 1'b0;
            s_match = 1'b0;
        end else if (scl_p && scl_now && !sda_p && sda_now) begin
            stop_cnt++;
            // drop the scl rise that belongs to the STOP condition
            if (bus_bits.size() > 0) void'(bus_bits.pop_back());
        end else if (!scl_p && scl_now) begin
            rises++;
            bus_bits.push_back(sda_now);
            if (rises <= 8) s_sh = {s_sh[6:0], sda_now};
            else if (rises >= 10 && rises <= 17 && s_match && !s_rw) begin
                s_wtmp = {s_wtmp[6:0], sda_now};
                if (rises == 17) s_wbyte = s_wtmp;
            end
        end else if (scl_p && !scl_now) begin
            if (rises == 8) begin
                s_match = (s_sh[7:1] == 7'h51);
                s_rw    = s_sh[0];
                s_low   = s_match;
            end else if (rises >= 9 && rises <= 16 && s_match && s_rw)
                s_low = ~s_rbyte[16 - rises];
            else if (rises == 17 && s_match && !s_rw)
                s_low = 1'b1;
            else
                s_low = 1'b0;
        end
        scl_p = scl_now;
        sda_p = sda_now;
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [17:0] bus_vec();
        logic [17:0] v = '0;
        for (int i = 0; i < bus_bits.size() && i < 18; i++) v[17-i] = bus_bits[i];
        return v;
    endfunction

    // Runs one transaction; optionally re-pulses start with other operands mid-way.
    task automatic do_txn(input logic [6:0] a, input logic [7:0] d, input logic r,
                          input int repulse_at, output int cyc);
        @(negedge clk);
        addr = a; data_in = d; rw = r; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (busy && cyc < 300) begin
            cyc++;
            if (repulse_at != 0 && cyc == repulse_at) begin
                start = 1'b1; addr = 7'h22; data_in = 8'h0F; rw = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (cyc >= 300) begin
            n_vec++; n_miss++;
            $display("FAIL txn_timeout: busy still high after %0d cycles, required low", cyc);
        end
        #1;
    endtask

    typedef struct {
        logic [6:0]  a;
        logic [7:0]  d;
        logic        r;
        logic [7:0]  rbyte;
        int          nbits;
        logic [17:0] bits;
        int          cycles;
        logic        exp_ack;
        logic [7:0]  exp_dout;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int stops0;

        vecs[0] = '{7'h51, 8'hA5, 1'b0, 8'h00, 18, {7'h51, 1'b0, 1'b0, 8'hA5, 1'b0}, 77, 1'b0, 8'h00};
        vecs[1] = '{7'h22, 8'hA5, 1'b0, 8'h00,  9, {7'h22, 1'b0, 1'b1, 9'h000},       41, 1'b1, 8'h00};
        vecs[2] = '{7'h51, 8'h00, 1'b1, 8'h3C, 18, {7'h51, 1'b1, 1'b0, 8'h3C, 1'b1}, 77, 1'b0, 8'h3C};
        vecs[3] = '{7'h51, 8'hFF, 1'b0, 8'h00, 18, {7'h51, 1'b0, 1'b0, 8'hFF, 1'b0}, 77, 1'b0, 8'h3C};
        vecs[4] = '{7'h50, 8'h00, 1'b1, 8'h00,  9, {7'h50, 1'b1, 1'b1, 9'h000},       41, 1'b1, 8'h3C};
        vecs[5] = '{7'h51, 8'h00, 1'b1, 8'h81, 18, {7'h51, 1'b1, 1'b0, 8'h81, 1'b1}, 77, 1'b0, 8'h81};
        vecs[6] = '{7'h51, 8'h00, 1'b0, 8'h00, 18, {7'h51, 1'b0, 1'b0, 8'h00, 1'b0}, 77, 1'b0, 8'h81};
        vecs[7] = '{7'h7F, 8'h00, 1'b0, 8'h00,  9, {7'h7F, 1'b0, 1'b1, 9'h000},       41, 1'b1, 8'h81};

        // Reset with start held high: start must be ignored.
        rst = 1'b1; start = 1'b1; addr = 7'h51; data_in = 8'hA5; rw = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk); #1;
        chk("reset_busy",      {31'd0, busy},      32'd0);
        chk("reset_scl",       {31'd0, scl},       32'd1);
        chk("reset_sda",       {31'd0, sda},       32'd1);
        chk("reset_ack_error", {31'd0, ack_error}, 32'd0);
        chk("reset_data_out",  {24'd0, data_out},  32'h00);

        for (int i = 0; i < 8; i++) begin
            s_rbyte = vecs[i].rbyte;
            stops0  = stop_cnt;
            do_txn(vecs[i].a, vecs[i].d, vecs[i].r, 0, cyc);
            chk($sformatf("v%0d_busy_cycles", i), cyc, vecs[i].cycles);
            chk($sformatf("v%0d_nbits", i), bus_bits.size(), vecs[i].nbits);
            chk($sformatf("v%0d_bits", i), {14'd0, bus_vec()}, {14'd0, vecs[i].bits});
            chk($sformatf("v%0d_ack_error", i), {31'd0, ack_error}, {31'd0, vecs[i].exp_ack});
            chk($sformatf("v%0d_data_out", i), {24'd0, data_out}, {24'd0, vecs[i].exp_dout});
            chk($sformatf("v%0d_stop", i), stop_cnt - stops0, 1);
            chk($sformatf("v%0d_idle_scl", i), {31'd0, scl}, 32'd1);
            chk($sformatf("v%0d_idle_sda", i), {31'd0, sda}, 32'd1);
            if (!vecs[i].r && !vecs[i].exp_ack)
                chk($sformatf("v%0d_slave_byte", i), {24'd0, s_wbyte}, {24'd0, vecs[i].d});
        end

        // start re-pulsed mid-write with different operands must be ignored.
        do_txn(7'h51, 8'hC3, 1'b0, 30, cyc);
        chk("repulse_busy_cycles", cyc, 77);
        chk("repulse_bits", {14'd0, bus_vec()}, {14'd0, 7'h51, 1'b0, 1'b0, 8'hC3, 1'b0});
        chk("repulse_slave_byte", {24'd0, s_wbyte}, 32'hC3);
        chk("repulse_ack_error", {31'd0, ack_error}, 32'd0);

        // Reset in the middle of the address byte aborts without STOP.
        @(negedge clk);
        addr = 7'h51; data_in = 8'h99; rw = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (bus_bits.size() < 3 && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        chk("abort_reached_addr", {31'd0, (cyc < 100)}, 32'd1);
        rst = 1'b1;
        @(negedge clk); #1;
        chk("abort_scl",       {31'd0, scl},       32'd1);
        chk("abort_sda",       {31'd0, sda},       32'd1);
        chk("abort_busy",      {31'd0, busy},      32'd0);
        chk("abort_ack_error", {31'd0, ack_error}, 32'd0);
        chk("abort_data_out",  {24'd0, data_out},  32'h00);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        do_txn(7'h51, 8'h5A, 1'b0, 0, cyc);
        chk("post_abort_cycles", cyc, 77);
        chk("post_abort_bits", {14'd0, bus_vec()}, {14'd0, 7'h51, 1'b0, 1'b0, 8'h5A, 1'b0});
        chk("post_abort_slave_byte", {24'd0, s_wbyte}, 32'h5A);
        chk("post_abort_ack_error", {31'd0, ack_error}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
